// File: rtl/tdc_sample_accum_pkg.sv
// Shared types and defaults for the TDC sample accumulator.
package tdc_pkg;

  localparam int TDC_N_DEF            = 64;
  localparam int TDC_LOG2_SAMPLES_DEF = 4;

  // Count width able to hold 0..n inclusive.
  function automatic int tdc_cw(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} tdc_acc_state_e;

endpackage

// File: rtl/tdc_sample_accum_if.sv
// Sample input and result handshake bundle for tdc_sample_accum.
interface tdc_sample_accum_if #(
  parameter int N            = 64,
  parameter int LOG2_SAMPLES = 4
);
  import tdc_pkg::*;

  localparam int CW = tdc_cw(N);
  localparam int SW = CW + LOG2_SAMPLES;

  logic          in_valid;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic [CW-1:0] out_mean;
  logic [CW-1:0] out_min;
  logic [CW-1:0] out_max;

  modport master (
    output in_valid, in_count, out_ready,
    input  out_valid, out_sum, out_mean, out_min, out_max
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output out_valid, out_sum, out_mean, out_min, out_max
  );
endinterface

// File: rtl/tdc_minmax_track.sv
// Running min/max of the clamped samples; *_next folds in the current sample
// so the final latch can include it in the same cycle.
module tdc_minmax_track #(
  parameter int CW = 7,
  parameter int N  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          upd,
  input  logic [CW-1:0] sample,
  output logic [CW-1:0] min_next,
  output logic [CW-1:0] max_next
);
  localparam logic [CW-1:0] NMAX = CW'(N);

  logic [CW-1:0] min_q, max_q;

  assign min_next = (upd && sample < min_q) ? sample : min_q;
  assign max_next = (upd && sample > max_q) ? sample : max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else if (clr) begin
      min_q <= NMAX;
      max_q <= '0;
    end else if (upd) begin
      min_q <= min_next;
      max_q <= max_next;
    end
  end
endmodule

// File: rtl/tdc_sample_accum.sv
// Accumulates 2^LOG2_SAMPLES TDC pop-count samples per start and presents
// sum/mean (and min/max when TDC_MINMAX_EN is defined) on a valid/ready port.
module tdc_sample_accum
  import tdc_pkg::*;
#(
  parameter int N            = TDC_N_DEF,
  parameter int LOG2_SAMPLES = TDC_LOG2_SAMPLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                overrun,
  tdc_sample_accum_if.slave   bus
);
  localparam int CW = tdc_cw(N);
  localparam int SW = CW + LOG2_SAMPLES;
  localparam logic [CW-1:0] NMAX = CW'(N);

  tdc_acc_state_e state_q, state_d;

  logic                    clr, take, fin, drop;
  logic [CW-1:0]           samp;
  logic [SW-1:0]           acc_q, sum_next;
  logic [LOG2_SAMPLES-1:0] cnt_q;
  logic                    ovr_q;
  logic [SW-1:0]           sum_q;
  logic [CW-1:0]           mean_q, min_q, max_q;

  // Out-of-range counts saturate so the accumulator cannot wrap.
  assign samp     = (bus.in_count > NMAX) ? NMAX : bus.in_count;
  assign sum_next = acc_q + SW'(samp);

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    take    = 1'b0;
    fin     = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        clr     = 1'b1;
        state_d = ACCUM;
      end
      ACCUM: if (bus.in_valid) begin
        take = 1'b1;
        if (&cnt_q) begin
          fin     = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        drop = bus.in_valid;
        if (bus.out_ready) begin
          clr     = start;
          state_d = start ? ACCUM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      sum_q  <= '0;
      mean_q <= '0;
    end else begin
      if (clr) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (take) begin
        acc_q <= sum_next;
        cnt_q <= cnt_q + 1'b1;
      end
      // A start in the handshake cycle wins over a dropped sample.
      if (clr)       ovr_q <= 1'b0;
      else if (drop) ovr_q <= 1'b1;
      if (fin) begin
        sum_q  <= sum_next;
        mean_q <= sum_next[SW-1:LOG2_SAMPLES];
      end
    end
  end

`ifdef TDC_MINMAX_EN
  logic [CW-1:0] min_nx, max_nx;

  tdc_minmax_track #(.CW(CW), .N(N)) u_minmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .upd      (take),
    .sample   (samp),
    .min_next (min_nx),
    .max_next (max_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else if (fin) begin
      min_q <= min_nx;
      max_q <= max_nx;
    end
  end
`else
  assign min_q = '0;
  assign max_q = '0;
`endif

  assign busy          = (state_q == ACCUM);
  assign overrun       = ovr_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_mean  = mean_q;
  assign bus.out_min   = min_q;
  assign bus.out_max   = max_q;
endmodule

// File: doc/tdc_sample_accum.md
Name: tdc_sample_accum

Overview:
- Downstream of the TDC pop-count stage: consumes the registered ones-count of the delay-line thermometer code, one sample per enabled cycle.
- On a start request it accumulates exactly 2^LOG2_SAMPLES valid samples.
- It then presents sum, mean, and optionally min/max on a valid/ready output handshake.
- Provides an averaged, jitter-reduced TDC reading for the readout/scan logic.

Parameters:
- N, 64, delay-line length; input count width CW = $clog2(N)+1 (7 at default).
- LOG2_SAMPLES, 4, log2 of samples per measurement (1..8); SW = CW+LOG2_SAMPLES.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a measurement.
- in_valid  in  1  in_count is a valid sample this cycle (driven from the pop-count enable, delayed one cycle).
- in_count  in  CW  pop-count sample, legal range 0..N.
- busy  out  1  high in ACCUM.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  SW  sum of samples.
- out_mean  out  CW  out_sum >> LOG2_SAMPLES (truncating).
- out_min  out  CW  smallest sample (feature-dependent).
- out_max  out  CW  largest sample (feature-dependent).
- overrun  out  1  sticky: a sample arrived in HOLD and was dropped.

Behaviour:
- Reset (async assert, sync-released by the top level): state IDLE; all outputs 0; accumulator, sample counter and overrun cleared.
- FSM IDLE: start=1 -> ACCUM; acc<=0, cnt<=0, min<=N, max<=0, overrun<=0. in_valid ignored, not flagged.
- FSM ACCUM: each in_valid cycle: acc+=in_count, cnt+=1, min/max updated.
  - When in_valid and cnt==2^LOG2_SAMPLES-1: latch final results (including that sample) into output registers, out_valid<=1 -> HOLD.
  - Latency: out_valid high the cycle after the last sample is presented.
  - start ignored in ACCUM. in_valid=0 cycles are skipped; there is no timeout.
- FSM HOLD: outputs stable while out_valid=1.
  - out_valid&&out_ready -> out_valid<=0 on the next edge, -> IDLE.
  - If start is also high in the handshake cycle -> directly to ACCUM with the clears above; overrun is still cleared.
  - in_valid in HOLD: sample dropped, overrun<=1; it persists until the next accepted start.
- Input clamp: in_count>N is saturated to N before use, so the accumulator never exceeds N*2^LOG2_SAMPLES and cannot overflow SW bits.
- out_valid is never deasserted without out_ready; the output registers change only on the final-sample latch.
- rst_n assertion mid-ACCUM or mid-HOLD discards the measurement immediately; no partial result is emitted.

Optional Feature:
- Macro TDC_MINMAX_EN.
- Defined: per-measurement min/max registers are tracked and latched to out_min/out_max alongside out_sum.
- Undefined: no min/max registers; out_min and out_max tie to 0.
- Sum, mean and handshake timing are identical in both builds.

Decomposition:
- Package tdc_pkg:
  - function tdc_cw(N) returning $clog2(N)+1.
  - state enum typedef tdc_acc_state_e {IDLE, ACCUM, HOLD}.
  - localparam defaults for N and LOG2_SAMPLES.
- One sub-module tdc_minmax_track: CW-wide running min/max with clear and update inputs, instantiated only under TDC_MINMAX_EN.

Test Plan:
- N=64, LOG2_SAMPLES=2; start, then samples 10,20,30,41 back-to-back -> one cycle after 41: out_valid=1, out_sum=101, out_mean=25, out_min=10, out_max=41, busy=0.
- Same samples with in_valid gaps of 0–3 idle cycles between them -> identical results; out_valid only after the 4th valid sample.
- Hold out_ready=0 for 10 cycles with in_valid=1 -> outputs stable, overrun=1. Then out_ready=1 with start=1 in the same cycle -> ACCUM, overrun=0, out_valid=0 next edge.
- Four samples of value 64, then four of 127 (illegal) -> first measurement: sum 256, mean 64. Second: clamped, sum 256, max 64.
- Pull rst_n low after 2 of 4 samples -> all outputs 0 asynchronously. After release, no out_valid without a new start. A new start with samples 1,1,1,2 -> sum 5, mean 1.
- Build without TDC_MINMAX_EN, rerun the first scenario -> sum 101 and mean 25 match, out_min=out_max=0.
